// File: rtl/parity_engine.sv
// parity_engine: serial 16550-style parity generator / checker.
// Optional PARITY_ERR_CNT_EN adds a saturating 8-bit parity error counter.
module parity_engine #(
  parameter int MAX_DATA_LENGTH = 8
) (
  input  logic                       i_sys_clk,
  input  logic                       i_sys_rst_n,
  input  logic                       i_start,
  input  logic                       i_bit_valid,
  input  logic                       i_bit,
  input  logic [1:0]                 i_word_len,
  input  logic                       i_pen,
  input  logic                       i_eps,
  input  logic                       i_stick,
  input  logic                       i_check,
  input  logic                       i_err_clr,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_parity_bit,
  output logic [MAX_DATA_LENGTH-1:0] o_data,
  output logic                       o_parity_err,
  output logic [7:0]                 o_err_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [3:0] MAX_LEN = 4'(MAX_DATA_LENGTH);

  logic [1:0]                 state_q;
  logic [3:0]                 len_q;
  logic [3:0]                 cnt_q;
  logic                       pen_q;
  logic                       eps_q;
  logic                       stick_q;
  logic                       chk_q;
  logic                       acc_q;
  logic                       par_q;
  logic [MAX_DATA_LENGTH-1:0] data_q;
  logic                       err_q;

  logic [3:0] len_w;
  logic       acc_nx;
  logic       par_calc;
  logic       last_bit;
  logic       err_set;

  // active length, clamped to the widest supported character
  always_comb begin
    len_w = 4'd5 + {2'b00, i_word_len};
    if (len_w > MAX_LEN) len_w = MAX_LEN;
  end

  // parity of the data including the bit arriving this cycle
  always_comb begin
    acc_nx   = acc_q ^ i_bit;
    par_calc = 1'b0;
    if (pen_q) begin
      if (stick_q)    par_calc = ~eps_q;
      else if (eps_q) par_calc = acc_nx;
      else            par_calc = ~acc_nx;
    end
  end

  assign last_bit = (cnt_q == len_q - 4'd1);

  assign err_set = (state_q == PARITY) && i_bit_valid && !i_start &&
                   chk_q && pen_q && (i_bit != par_q);

  // character FSM, shift assembly and parity accumulation
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q <= IDLE;
      len_q   <= 4'd0;
      cnt_q   <= 4'd0;
      pen_q   <= 1'b0;
      eps_q   <= 1'b0;
      stick_q <= 1'b0;
      chk_q   <= 1'b0;
      acc_q   <= 1'b0;
      par_q   <= 1'b0;
      data_q  <= '0;
    end else if (i_start) begin
      state_q <= DATA;
      len_q   <= len_w;
      cnt_q   <= 4'd0;
      pen_q   <= i_pen;
      eps_q   <= i_eps;
      stick_q <= i_stick;
      chk_q   <= i_check;
      acc_q   <= 1'b0;
      par_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        DATA: begin
          if (i_bit_valid) begin
            acc_q  <= acc_nx;
            data_q <= data_q |
                      (MAX_DATA_LENGTH'(i_bit) << cnt_q);
            cnt_q  <= cnt_q + 4'd1;
            if (last_bit) begin
              par_q   <= par_calc;
              state_q <= (chk_q && pen_q) ? PARITY : DONE;
            end
          end
        end
        PARITY: begin
          if (i_bit_valid) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // sticky error flag; a new error wins over a clear
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n)   err_q <= 1'b0;
    else if (err_set)   err_q <= 1'b1;
    else if (i_err_clr) err_q <= 1'b0;
  end

`ifdef PARITY_ERR_CNT_EN
  logic [7:0] cnt_err_q;

  // saturating error count; error with clear restarts at one
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      cnt_err_q <= 8'd0;
    end else if (err_set) begin
      if (i_err_clr)               cnt_err_q <= 8'd1;
      else if (cnt_err_q != 8'hFF) cnt_err_q <= cnt_err_q + 8'd1;
    end else if (i_err_clr) begin
      cnt_err_q <= 8'd0;
    end
  end

  assign o_err_cnt = cnt_err_q;
`else
  assign o_err_cnt = 8'd0;
`endif

  assign o_busy       = (state_q == DATA) || (state_q == PARITY);
  assign o_done       = (state_q == DONE);
  assign o_parity_bit = par_q;
  assign o_data       = data_q;
  assign o_parity_err = err_q;

endmodule

// File: tb/tb_parity_engine.sv
// tb_parity_engine: directed checks for parity_engine.
// Covers generate, check, stick, restart, error clear and reset.
module tb_parity_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_bit_valid = 1'b0;
  logic       i_bit = 1'b0;
  logic [1:0] i_word_len = 2'b00;
  logic       i_pen = 1'b0;
  logic       i_eps = 1'b0;
  logic       i_stick = 1'b0;
  logic       i_check = 1'b0;
  logic       i_err_clr = 1'b0;
  logic       o_busy;
  logic       o_done;
  logic       o_parity_bit;
  logic [7:0] o_data;
  logic       o_parity_err;
  logic [7:0] o_err_cnt;

  int vecs = 0;
  int miscmp = 0;
  int done_seen = 0;

`ifdef PARITY_ERR_CNT_EN
  localparam logic [7:0] CNT1 = 8'd1;
  localparam logic [7:0] CNT2 = 8'd2;
`else
  localparam logic [7:0] CNT1 = 8'd0;
  localparam logic [7:0] CNT2 = 8'd0;
`endif

  parity_engine #(.MAX_DATA_LENGTH(8)) dut (
    .i_sys_clk    (clk),
    .i_sys_rst_n  (rst_n),
    .i_start      (i_start),
    .i_bit_valid  (i_bit_valid),
    .i_bit        (i_bit),
    .i_word_len   (i_word_len),
    .i_pen        (i_pen),
    .i_eps        (i_eps),
    .i_stick      (i_stick),
    .i_check      (i_check),
    .i_err_clr    (i_err_clr),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_parity_bit (o_parity_bit),
    .o_data       (o_data),
    .o_parity_err (o_parity_err),
    .o_err_cnt    (o_err_cnt)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (o_done) done_seen++;

  task automatic start_char(input logic [1:0] wls, input logic pen,
                            input logic eps, input logic stick,
                            input logic chk);
    i_start = 1'b1;
    i_word_len = wls;
    i_pen = pen;
    i_eps = eps;
    i_stick = stick;
    i_check = chk;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    i_bit_valid = 1'b1;
    i_bit = b;
    @(negedge clk);
    i_bit_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) send_bit(d[i]);
  endtask

  task automatic test_reset;
    #1;
    vecs++;
    if ({o_busy, o_done, o_parity_bit, o_data, o_parity_err, o_err_cnt}
        !== 20'd0) begin
      miscmp++;
      $display("FAIL reset_state: got busy=%b done=%b par=%b data=%h err=%b cnt=%0d want all 0",
               o_busy, o_done, o_parity_bit, o_data, o_parity_err, o_err_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_gen_a5;
    start_char(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs++;
    if (o_busy !== 1'b1) begin
      miscmp++;
      $display("FAIL a5_busy: got %b want 1", o_busy);
    end
    send_bits(8'hA5, 7);
    vecs++;
    if (o_done !== 1'b0) begin
      miscmp++;
      $display("FAIL a5_early_done: got %b want 0", o_done);
    end
    send_bit(1'b1);
    vecs++;
    if ({o_done, o_busy} !== 2'b10) begin
      miscmp++;
      $display("FAIL a5_done: got done/busy=%b want 10", {o_done, o_busy});
    end
    vecs++;
    if ({o_parity_bit, o_data} !== {1'b0, 8'hA5}) begin
      miscmp++;
      $display("FAIL a5_result: got par=%b data=%h want par=0 data=a5",
               o_parity_bit, o_data);
    end
    @(negedge clk);
    vecs++;
    if ({o_done, o_parity_bit, o_data} !== {1'b0, 1'b0, 8'hA5}) begin
      miscmp++;
      $display("FAIL a5_hold: got done=%b par=%b data=%h want 0 0 a5",
               o_done, o_parity_bit, o_data);
    end
  endtask

  task automatic test_gen_07;
    // a valid bit alongside the start pulse must be dropped
    i_bit_valid = 1'b1;
    i_bit = 1'b0;
    start_char(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    i_bit_valid = 1'b0;
    send_bits(8'h07, 4);
    vecs++;
    if (o_done !== 1'b0) begin
      miscmp++;
      $display("FAIL w5_early_done: got %b want 0", o_done);
    end
    send_bit(1'b0);
    vecs++;
    if ({o_done, o_parity_bit, o_data} !== {1'b1, 1'b0, 8'h07}) begin
      miscmp++;
      $display("FAIL w5_result: got done=%b par=%b data=%h want 1 0 07",
               o_done, o_parity_bit, o_data);
    end
    @(negedge clk);
    send_bit(1'b1);
    vecs++;
    if ({o_busy, o_data} !== {1'b0, 8'h07}) begin
      miscmp++;
      $display("FAIL idle_ignore: got busy=%b data=%h want 0 07",
               o_busy, o_data);
    end
  endtask

  task automatic test_stick;
    start_char(2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
    send_bits(8'h2A, 6);
    vecs++;
    if ({o_done, o_parity_bit, o_data} !== {1'b1, 1'b1, 8'h2A}) begin
      miscmp++;
      $display("FAIL stick_odd: got done=%b par=%b data=%h want 1 1 2a",
               o_done, o_parity_bit, o_data);
    end
    @(negedge clk);
    start_char(2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
    send_bits(8'h2B, 6);
    vecs++;
    if ({o_done, o_parity_bit, o_data} !== {1'b1, 1'b0, 8'h2B}) begin
      miscmp++;
      $display("FAIL stick_even: got done=%b par=%b data=%h want 1 0 2b",
               o_done, o_parity_bit, o_data);
    end
    @(negedge clk);
  endtask

  task automatic test_restart;
    done_seen = 0;
    start_char(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    send_bits(8'hFF, 3);
    start_char(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    send_bits(8'h3C, 8);
    vecs++;
    if ({o_done, o_data, o_parity_bit} !== {1'b1, 8'h3C, 1'b0}) begin
      miscmp++;
      $display("FAIL restart_result: got done=%b data=%h par=%b want 1 3c 0",
               o_done, o_data, o_parity_bit);
    end
    repeat (3) @(negedge clk);
    vecs++;
    if (done_seen !== 1) begin
      miscmp++;
      $display("FAIL restart_done_count: got %0d want 1", done_seen);
    end
  endtask

  task automatic test_check_err;
    start_char(2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
    send_bits(8'h01, 8);
    vecs++;
    if ({o_done, o_busy, o_parity_bit} !== 3'b011) begin
      miscmp++;
      $display("FAIL chk_wait_parity: got done/busy/par=%b want 011",
               {o_done, o_busy, o_parity_bit});
    end
    send_bit(1'b0);
    vecs++;
    if ({o_done, o_parity_err, o_err_cnt} !== {1'b1, 1'b1, CNT1}) begin
      miscmp++;
      $display("FAIL chk_err: got done=%b err=%b cnt=%0d want 1 1 %0d",
               o_done, o_parity_err, o_err_cnt, CNT1);
    end
    @(negedge clk);
    start_char(2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
    send_bits(8'h03, 8);
    send_bit(1'b1);
    vecs++;
    if ({o_parity_err, o_err_cnt} !== {1'b1, CNT2}) begin
      miscmp++;
      $display("FAIL chk_err2: got err=%b cnt=%0d want 1 %0d",
               o_parity_err, o_err_cnt, CNT2);
    end
    @(negedge clk);
  endtask

  task automatic test_err_clr;
    start_char(2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
    send_bits(8'h00, 8);
    i_err_clr = 1'b1;
    send_bit(1'b0);
    i_err_clr = 1'b0;
    vecs++;
    if ({o_parity_err, o_err_cnt} !== {1'b1, CNT1}) begin
      miscmp++;
      $display("FAIL clr_vs_err: got err=%b cnt=%0d want 1 %0d",
               o_parity_err, o_err_cnt, CNT1);
    end
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    vecs++;
    if ({o_parity_err, o_err_cnt} !== 9'd0) begin
      miscmp++;
      $display("FAIL clr_only: got err=%b cnt=%0d want 0 0",
               o_parity_err, o_err_cnt);
    end
    start_char(2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
    send_bits(8'h00, 8);
    send_bit(1'b1);
    vecs++;
    if ({o_done, o_parity_err, o_err_cnt} !== {1'b1, 1'b0, 8'd0}) begin
      miscmp++;
      $display("FAIL chk_good: got done=%b err=%b cnt=%0d want 1 0 0",
               o_done, o_parity_err, o_err_cnt);
    end
    start_char(2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
    send_bits(8'h01, 8);
    vecs++;
    if ({o_done, o_parity_err, o_parity_bit} !== 3'b100) begin
      miscmp++;
      $display("FAIL chk_nopen: got done/err/par=%b want 100",
               {o_done, o_parity_err, o_parity_bit});
    end
    @(negedge clk);
    start_char(2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
    send_bits(8'h01, 8);
    send_bit(1'b0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    start_char(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    send_bits(8'h0F, 4);
    vecs++;
    if ({o_busy, o_data} !== {1'b1, 8'h0F}) begin
      miscmp++;
      $display("FAIL mid_pre: got busy=%b data=%h want 1 0f", o_busy, o_data);
    end
    #5;
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({o_busy, o_done, o_parity_bit, o_data, o_parity_err, o_err_cnt}
        !== 20'd0) begin
      miscmp++;
      $display("FAIL mid_reset: got busy=%b done=%b par=%b data=%h err=%b cnt=%0d want all 0",
               o_busy, o_done, o_parity_bit, o_data, o_parity_err, o_err_cnt);
    end
    done_seen = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_bits(8'hFF, 5);
    repeat (2) @(negedge clk);
    vecs++;
    if ({o_busy, o_data, done_seen[7:0]} !== {1'b0, 8'h00, 8'd0}) begin
      miscmp++;
      $display("FAIL mid_after: got busy=%b data=%h dones=%0d want 0 00 0",
               o_busy, o_data, done_seen);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_gen_a5;
    test_gen_07;
    test_stick;
    test_restart;
    test_check_err;
    test_err_clr;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
